// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with a valid/ready handshake on both sides.
module alu_muldiv #(
  parameter int unsigned XLEN      = 32,
  parameter bit          EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned     CW   = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, result_q, result_d;

  logic            a_sgn, b_sgn, a_neg, b_neg, b_zero, div_ovf, special, neg_in;
  logic [XLEN-1:0] a_mag, b_mag, spec_val;

  always_comb begin
    a_sgn   = (funct != 3'd3) && (funct != 3'd5) && (funct != 3'd7);
    b_sgn   = a_sgn && (funct != 3'd2);
    a_neg   = a_sgn & src1[XLEN-1];
    b_neg   = b_sgn & src2[XLEN-1];
    a_mag   = a_neg ? (~src1 + 1'b1) : src1;
    b_mag   = b_neg ? (~src2 + 1'b1) : src2;
    b_zero  = (src2 == '0);
    div_ovf = funct[2] & ~funct[0] & (src1 == SMIN) & (&src2);
    special = funct[2] & (b_zero | div_ovf);
    if (b_zero) spec_val = funct[1] ? src1 : '1;
    else        spec_val = funct[1] ? '0 : src1;
    // A zero divisor must leave the all-ones quotient unsigned-looking, so never negate it.
    if (!funct[2])      neg_in = a_neg ^ b_neg;
    else if (!funct[1]) neg_in = (a_neg ^ b_neg) & ~b_zero;
    else                neg_in = a_neg;
  end

  logic [XLEN:0] mul_sum, div_shift, div_diff;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
  end

  logic [2*XLEN-1:0] prod_abs, prod;
  logic [XLEN-1:0]   qr_abs, qr, fix_val;

  always_comb begin
    prod_abs = {hi_q, lo_q};
    prod     = neg_q ? (~prod_abs + 1'b1) : prod_abs;
    qr_abs   = op_q[1] ? hi_q : lo_q;
    qr       = neg_q ? (~qr_abs + 1'b1) : qr_abs;
    if (op_q[2])              fix_val = qr;
    else if (op_q[1:0] == '0) fix_val = prod[XLEN-1:0];
    else                      fix_val = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !kill) begin
          op_d  = funct;
          neg_d = neg_in;
          hi_d  = '0;
          lo_d  = a_mag;
          b_d   = b_mag;
          cnt_d = '0;
          if (EARLY_OUT && special) begin
            result_d = spec_val;
            state_d  = S_DONE;
          end else begin
            state_d  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          if (!op_q[2]) begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end else if (!div_diff[XLEN]) begin
            hi_d = div_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_val;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (kill || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: a 32-bit early-out instance and a 16-bit full-latency
// instance, checked every cycle against an arithmetic model of RV32M semantics.
module tb_alu_muldiv;

  typedef longint unsigned u64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid, kill, out_ready;
  logic [2:0]  fn [2];
  logic [31:0] s1 [2];
  logic [31:0] s2 [2];
  logic        ir_a, ov_a, ir_b, ov_b;
  logic [31:0] res_a;
  logic [15:0] res_b;
  logic [1:0]  in_ready, out_valid;
  logic [31:0] res [2];

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(32), .EARLY_OUT(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir_a), .funct(fn[0]),
    .src1(s1[0]), .src2(s2[0]), .kill(kill[0]), .out_valid(ov_a), .out_ready(out_ready[0]),
    .result(res_a));

  alu_muldiv #(.XLEN(16), .EARLY_OUT(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir_b), .funct(fn[1]),
    .src1(s1[1][15:0]), .src2(s2[1][15:0]), .kill(kill[1]), .out_valid(ov_b), .out_ready(out_ready[1]),
    .result(res_b));

  assign in_ready  = {ir_b, ir_a};
  assign out_valid = {ov_b, ov_a};
  assign res[0]    = res_a;
  assign res[1]    = {16'h0, res_b};

  task automatic chk(input string nm, input int d, input u64 act, input u64 exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s (dut%0d) at cycle %0d: got %0h, expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  // RV32M result from plain signed/unsigned integer arithmetic on xl-bit operands.
  function automatic u64 model(input logic [2:0] f, input u64 a, input u64 b, input int xl);
    u64 mask, pu;
    longint sa, sb, p;
    mask = (64'd1 << xl) - 64'd1;
    sa = a[xl-1] ? $signed(a | ~mask) : $signed(a);
    sb = b[xl-1] ? $signed(b | ~mask) : $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return $unsigned(p) & mask; end
      3'd1: begin p = sa * sb; return $unsigned(p >>> xl) & mask; end
      3'd2: begin p = sa * $signed(b); return $unsigned(p >>> xl) & mask; end
      3'd3: begin pu = a * b; return (pu >> xl) & mask; end
      3'd4: begin
        if (b == 0) return mask;
        if (a == (64'd1 << (xl-1)) && b == mask) return a;
        return $unsigned(sa / sb) & mask;
      end
      3'd5: return (b == 0) ? mask : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == (64'd1 << (xl-1)) && b == mask) return 0;
        return $unsigned(sa % sb) & mask;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input u64 a, input u64 b, input int xl);
    u64 mask;
    mask = (64'd1 << xl) - 64'd1;
    return f[2] && (b == 0 || (!f[0] && a == (64'd1 << (xl-1)) && b == mask));
  endfunction

  // Compare process: one outstanding op per instance, due at accept + latency.
  bit pend [2];
  u64 pexp [2];
  int pdue [2];
  int cmp_xl;
  bit cmp_ev;

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      cmp_xl = (d == 0) ? 32 : 16;
      if (!rst_n) begin
        pend[d] = 1'b0;
        chk("reset in_ready", d, in_ready[d], 1);
        chk("reset out_valid", d, out_valid[d], 0);
        chk("reset result", d, res[d], 0);
      end else begin
        cmp_ev = pend[d] && (cyc >= pdue[d]);
        chk("in_ready", d, in_ready[d], !pend[d]);
        chk("out_valid", d, out_valid[d], cmp_ev);
        if (cmp_ev) chk("result", d, res[d], pexp[d]);
        if (pend[d]) begin
          if (kill[d] || (cmp_ev && out_ready[d])) pend[d] = 1'b0;
        end else if (in_valid[d] && !kill[d]) begin
          pend[d] = 1'b1;
          pexp[d] = model(fn[d], u64'(s1[d]), u64'(s2[d]), cmp_xl);
          pdue[d] = cyc + (((d == 0) && is_special(fn[d], u64'(s1[d]), u64'(s2[d]), cmp_xl))
                           ? 1 : cmp_xl + 2);
        end
      end
    end
  end

  task automatic run_a(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, input int lat, input int hold);
    int n;
    @(posedge clk); #1;
    chk("idle before op", 0, in_ready[0], 1);
    in_valid[0] = 1'b1; fn[0] = f; s1[0] = a; s2[0] = b;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid[0] && n < 100);
    chk($sformatf("latency f%0d", f), 0, n, lat);
    chk($sformatf("literal f%0d %h/%h", f, a, b), 0, res[0], lit);
    repeat (hold) begin
      @(negedge clk);
      chk("held result", 0, res[0], lit);
      chk("held in_ready", 0, in_ready[0], 0);
    end
    @(posedge clk); #1 out_ready[0] = 1'b1;
    @(posedge clk); #1 out_ready[0] = 1'b0;
    chk("idle after handshake", 0, in_ready[0], 1);
  endtask

  function automatic logic [31:0] pick(input int xl);
    u64 mask;
    mask = (64'd1 << xl) - 64'd1;
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'(mask);
      2: return 32'(64'd1 << (xl-1));
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      5: return 32'(mask - u64'($urandom_range(0, 20)));
      default: return 32'(u64'($urandom) & mask);
    endcase
  endfunction

  task automatic rand_drive(input int d, input int ncyc);
    int xl;
    xl = (d == 0) ? 32 : 16;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      in_valid[d]  = 1'($urandom_range(0, 1));
      fn[d]        = 3'($urandom_range(0, 7));
      s1[d]        = pick(xl);
      s2[d]        = pick(xl);
      out_ready[d] = ($urandom_range(0, 3) != 0);
      kill[d]      = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0; kill[d] = 1'b0; out_ready[d] = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    in_valid = '0; kill = '0; out_ready = '0;
    for (int d = 0; d < 2; d++) begin fn[d] = '0; s1[d] = '0; s2[d] = '0; end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_a(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 5);
    run_a(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
    run_a(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34, 0);
    run_a(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);
    run_a(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    run_a(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    run_a(3'd5, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 34, 0);
    run_a(3'd7, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 34, 0);
    run_a(3'd4, 32'd123, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_a(3'd7, 32'd5, 32'd0, 32'd5, 1, 0);
    run_a(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_a(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

    // kill while the iteration counter reads 10
    @(posedge clk); #1;
    in_valid[0] = 1'b1; fn[0] = 3'd1; s1[0] = 32'h1234; s2[0] = 32'h5678;
    @(posedge clk); #1 in_valid[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 kill[0] = 1'b1;
    @(posedge clk); #1 kill[0] = 1'b0;
    chk("kill -> idle", 0, in_ready[0], 1);
    chk("kill -> no valid", 0, out_valid[0], 0);
    repeat (40) @(negedge clk);
    chk("no valid after kill", 0, out_valid[0], 0);
    run_a(3'd3, 32'd3, 32'd5, 32'd0, 34, 0);

    // asynchronous reset in the middle of a divide
    @(posedge clk); #1;
    in_valid[0] = 1'b1; fn[0] = 3'd5; s1[0] = 32'd1000; s2[0] = 32'd7;
    @(posedge clk); #1 in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid-op reset in_ready", 0, in_ready[0], 1);
    chk("mid-op reset out_valid", 0, out_valid[0], 0);
    chk("mid-op reset result", 0, res[0], 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no stale valid", 0, out_valid[0], 0);
    chk("no stale result", 0, res[0], 0);

    fork
      rand_drive(0, 40000);
      rand_drive(1, 40000);
    join
    repeat (50) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
